// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the banked multi-hart register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  function automatic int rf_addr_bits(input int hart_bits, input int reg_bits);
    return hart_bits + reg_bits;
  endfunction

  function automatic int rf_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/regfile_banked.sv
// Per-hart register banks in one inferred RAM: two registered read ports, one
// write port with write-first bypass, optional hardwired x0 and a post-reset clear.
module regfile_banked
  import regfile_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int HART_BITS      = 2,
  parameter int REG_BITS       = 5,
  parameter int ZERO_REG       = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_BITS     = rf_addr_bits(HART_BITS, REG_BITS),
  localparam int DEPTH         = rf_depth(ADDR_BITS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] tick_raddr1,
  input  logic [ADDR_BITS-1:0] tick_raddr2,
  input  logic                 tick_rden,
  input  logic [ADDR_BITS-1:0] tick_waddr,
  input  logic [WIDTH-1:0]     tick_wdata,
  input  logic                 tick_wren,
  output logic [WIDTH-1:0]     get_rs1_ret,
  output logic [WIDTH-1:0]     get_rs2_ret,
  output logic                 get_ready_ret
);

  localparam logic [ADDR_BITS-1:0] LAST      = '1;
  localparam rf_state_e            RST_STATE = (CLEAR_ON_RESET != 0) ? RF_CLEAR : RF_RUN;

  rf_state_e            state_q;
  logic [ADDR_BITS-1:0] cnt_q;
  logic                 ready_q;
  logic [WIDTH-1:0]     rs1_q, rs1_d;
  logic [WIDTH-1:0]     rs2_q, rs2_d;

  // No reset on the array so it maps onto block RAM.
  logic [WIDTH-1:0]     mem [DEPTH];

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [WIDTH-1:0]     mem_wdata;
  logic                 wr_live;

  function automatic logic is_zero_reg(input logic [ADDR_BITS-1:0] a);
    return (ZERO_REG != 0) && (a[REG_BITS-1:0] == '0);
  endfunction

  assign wr_live = tick_wren && !is_zero_reg(tick_waddr);

  // Read data: array, overridden by a same-cycle write, overridden by x0.
  always_comb begin
    rs1_d = mem[tick_raddr1];
    if (wr_live && (tick_raddr1 == tick_waddr)) rs1_d = tick_wdata;
    if (is_zero_reg(tick_raddr1)) rs1_d = '0;

    rs2_d = mem[tick_raddr2];
    if (wr_live && (tick_raddr2 == tick_waddr)) rs2_d = tick_wdata;
    if (is_zero_reg(tick_raddr2)) rs2_d = '0;
  end

  // The single RAM write port is owned by the clear sequencer until RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    if (state_q == RF_CLEAR) begin
      mem_we = 1'b1;
    end else if (wr_live) begin
      mem_we    = 1'b1;
      mem_waddr = tick_waddr;
      mem_wdata = tick_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      unique case (state_q)
        RF_CLEAR: begin
          // Counter parks on the last index so it never starts a second pass.
          if (cnt_q == LAST) begin
            state_q <= RF_RUN;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RF_RUN: begin
          ready_q <= 1'b1;
          if (tick_rden) begin
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
          end
        end
      endcase
    end
  end

  assign get_rs1_ret   = rs1_q;
  assign get_rs2_ret   = rs2_q;
  assign get_ready_ret = ready_q;

endmodule

// File: tb/tb_regfile_banked.sv
// Directed and randomized bench for regfile_banked against a write-first array model.
module tb_regfile_banked;

  localparam int W     = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] raddr1 = '0, raddr2 = '0, waddr = '0;
  logic          rden = 1'b0, wren = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rs1, rs2;
  logic          ready;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] model [DEPTH];
  logic [W-1:0] exp1 = '0, exp2 = '0;

  regfile_banked dut (
    .clock        (clock),
    .reset        (reset),
    .tick_raddr1  (raddr1),
    .tick_raddr2  (raddr2),
    .tick_rden    (rden),
    .tick_waddr   (waddr),
    .tick_wdata   (wdata),
    .tick_wren    (wren),
    .get_rs1_ret  (rs1),
    .get_rs2_ret  (rs2),
    .get_ready_ret(ready)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_rd(input logic [AW-1:0] a);
    logic [4:0] r;
    r = a[4:0];
    return (r == 5'd0) ? '0 : model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp1 = '0;
    exp2 = '0;
  endtask

  // One RUN cycle: write-first semantics make bypass and x0 fall out of the model.
  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic re, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic [4:0] wr;
    wren = we; waddr = wa; wdata = wd; rden = re; raddr1 = a1; raddr2 = a2;
    step();
    wr = wa[4:0];
    if (we && wr != 5'd0) model[wa] = wd;
    if (re) begin
      exp1 = model_rd(a1);
      exp2 = model_rd(a2);
    end
  endtask

  task automatic idle_inputs();
    wren = 1'b0; rden = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
  endtask

  task automatic release_and_clear(input string tag);
    int rise_edge;
    rise_edge = 0;
    reset = 1'b0;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      step();
      if (ready && rise_edge == 0) rise_edge = i;
    end
    check({tag, "_ready_edge"}, W'(rise_edge), W'(DEPTH));
    model_clear();
  endtask

  initial begin
    idle_inputs();
    #1 reset = 1'b1;
    #1;
    check("rst_rs1", rs1, '0);
    check("rst_rs2", rs2, '0);
    check("rst_ready", {31'd0, ready}, '0);
    step();
    step();
    release_and_clear("clear0");

    // Whole array reads zero after the clear.
    for (int a = 0; a < DEPTH; a++) begin
      cycle(1'b0, '0, '0, 1'b1, AW'(a), AW'(DEPTH - 1 - a));
      check("clr_rd1", rs1, exp1);
      check("clr_rd2", rs2, exp2);
    end
    check("clr_rd_last", rs1, '0);

    // Hart 1 x3 written, hart 0 x3 untouched.
    cycle(1'b1, 7'h23, 32'h0000_0005, 1'b0, '0, '0);
    cycle(1'b0, '0, '0, 1'b1, 7'h23, 7'h03);
    check("h1x3", rs1, 32'h5);
    check("h0x3", rs2, 32'h0);

    // Same-cycle bypass on both ports.
    cycle(1'b1, 7'h44, 32'hDEAD_BEEF, 1'b1, 7'h44, 7'h44);
    check("byp1", rs1, 32'hDEAD_BEEF);
    check("byp2", rs2, 32'hDEAD_BEEF);

    // x0 of hart 1 ignores writes and has no bypass.
    cycle(1'b1, 7'h20, 32'hFFFF_FFFF, 1'b1, 7'h20, 7'h44);
    check("zero_byp", rs1, 32'h0);
    check("zero_other", rs2, 32'hDEAD_BEEF);
    cycle(1'b0, '0, '0, 1'b1, 7'h20, 7'h20);
    check("zero_rd", rs1, 32'h0);

    // Read enable hold while the register changes underneath.
    cycle(1'b1, 7'h05, 32'h0000_1234, 1'b1, 7'h05, 7'h05);
    check("hold_load", rs1, 32'h1234);
    cycle(1'b1, 7'h05, 32'h0000_9999, 1'b0, 7'h05, 7'h05);
    check("hold1", rs1, 32'h1234);
    check("hold2", rs2, 32'h1234);
    cycle(1'b0, '0, '0, 1'b0, 7'h05, 7'h05);
    check("hold_again", rs1, 32'h1234);
    cycle(1'b0, '0, '0, 1'b1, 7'h05, 7'h05);
    check("hold_upd1", rs1, 32'h9999);
    check("hold_upd2", rs2, 32'h9999);

    // Randomized traffic, addresses biased toward collisions with the write.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa, a1, a2;
      wa = AW'($urandom_range(0, DEPTH - 1));
      a1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      a2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      cycle(1'($urandom), wa, $urandom, ($urandom_range(0, 4) != 0), a1, a2);
      check("rnd_rs1", rs1, exp1);
      check("rnd_rs2", rs2, exp2);
      check("rnd_ready", {31'd0, ready}, 32'd1);
    end

    // Reset in RUN: asynchronous clear of outputs and ready.
    cycle(1'b0, '0, '0, 1'b1, 7'h44, 7'h05);
    check("pre_rst1", rs1, exp1);
    reset = 1'b1;
    #1;
    check("mid_rst_rs1", rs1, '0);
    check("mid_rst_rs2", rs2, '0);
    check("mid_rst_ready", {31'd0, ready}, '0);
    step();
    reset = 1'b0;

    // Traffic during clear is ignored; stop at counter 60 and reset again.
    for (int i = 0; i < 60; i++) begin
      wren = 1'b1; rden = 1'b1;
      waddr = AW'($urandom_range(0, DEPTH - 1));
      wdata = $urandom;
      raddr1 = waddr; raddr2 = 7'h44;
      step();
      if (i % 15 == 0) begin
        check("clr_hold_rs1", rs1, '0);
        check("clr_hold_ready", {31'd0, ready}, '0);
      end
    end
    reset = 1'b1;
    #1;
    check("rst60_ready", {31'd0, ready}, '0);
    check("rst60_rs2", rs2, '0);
    step();
    idle_inputs();
    release_and_clear("clear2");

    // Previously written registers were cleared again.
    cycle(1'b0, '0, '0, 1'b1, 7'h44, 7'h23);
    check("post_clr_44", rs1, exp1);
    check("post_clr_23", rs2, exp2);
    cycle(1'b0, '0, '0, 1'b1, 7'h05, 7'h7F);
    check("post_clr_05", rs1, exp1);
    check("post_clr_7f", rs2, exp2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
